// File: rtl/commit_trace_fifo.sv
// Commit trace FIFO: captures register writebacks (and, with TRACE_MEM_EN
// defined, data-memory stores/loads) into a first-word-fall-through queue.
module commit_trace_fifo #(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      reg_write_sig,
    input  logic [4:0]                reg_num,
    input  logic [DATA_W-1:0]         reg_data,
    input  logic                      wr,
    input  logic                      rd,
    input  logic [8:0]                addr,
    input  logic [DATA_W-1:0]         wr_data,
    input  logic [DATA_W-1:0]         rd_data,
    output logic                      trace_valid,
    input  logic                      trace_ready,
    output logic [DATA_W+15:0]        trace_data,
    output logic [$clog2(DEPTH):0]    count,
    output logic [15:0]               drop_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int EW = DATA_W + 16;
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];
    localparam logic [1:0] TYPE_REG   = 2'b00;
    localparam logic [1:0] TYPE_STORE = 2'b01;
    localparam logic [1:0] TYPE_LOAD  = 2'b10;

    logic [EW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic [15:0]   drop_cnt_q, drop_cnt_d;

    logic          reg_ev, st_ev, ld_ev, any_ev, full, pop, push_ok;
    logic [1:0]    n_ev;
    logic [2:0]    n_drop;
    logic [16:0]   drop_sum;
    logic [EW-1:0] push_entry;

    assign reg_ev = reg_write_sig && (reg_num != 5'd0);
`ifdef TRACE_MEM_EN
    assign st_ev = wr;
    assign ld_ev = rd;
`else
    logic unused_mem_in;
    assign st_ev = 1'b0;
    assign ld_ev = 1'b0;
    assign unused_mem_in = ^{wr, rd, addr, wr_data, rd_data};
`endif

    always_comb begin
        any_ev     = reg_ev || st_ev || ld_ev;
        n_ev       = {1'b0, reg_ev} + {1'b0, st_ev} + {1'b0, ld_ev};
        full       = (count_q == FULL_CNT);
        pop        = (count_q != '0) && trace_ready;
        // A full FIFO still takes the push when the head leaves this cycle.
        push_ok    = any_ev && (!full || pop);
        push_entry = {TYPE_LOAD, 5'd0, addr, rd_data};
        if (reg_ev)
            push_entry = {TYPE_REG, 9'd0, reg_num, reg_data};
        else if (st_ev)
            push_entry = {TYPE_STORE, 5'd0, addr, wr_data};

        n_drop = 3'd0;
        if (any_ev)
            n_drop = {1'b0, n_ev} - 3'd1;
        if (any_ev && !push_ok)
            n_drop = n_drop + 3'd1;
        drop_sum   = {1'b0, drop_cnt_q} + {14'd0, n_drop};
        drop_cnt_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];

        wr_ptr_d = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop     ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q;
        if (push_ok && !pop)
            count_d = count_q + (AW+1)'(1);
        else if (pop && !push_ok)
            count_d = count_q - (AW+1)'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            drop_cnt_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Storage needs no reset: an empty FIFO never exposes it.
    always_ff @(posedge clk) begin
        if (!reset && push_ok)
            mem_q[wr_ptr_q] <= push_entry;
    end

    assign trace_valid = (count_q != '0);
    assign trace_data  = trace_valid ? mem_q[rd_ptr_q] : '0;
    assign count       = count_q;
    assign drop_cnt    = drop_cnt_q;

endmodule

// File: doc/commit_trace_fifo.md
COMMIT_TRACE_FIFO -- requirements
Module: commit_trace_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 8, FIFO entries (power of two, 2..64).
REQ-002 SHALL have parameter DATA_W, default 32, data width of register and memory words.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port reg_write_sig, input, 1, the core's register writeback strobe.
REQ-006 SHALL have port reg_num, input, 5, the writeback destination register.
REQ-007 SHALL have port reg_data, input, DATA_W, the writeback value.
REQ-008 SHALL have ports wr and rd, input, 1 each, the core's data-memory store and load strobes.
REQ-009 SHALL have port addr, input, 9, the data-memory word address.
REQ-010 SHALL have ports wr_data and rd_data, input, DATA_W each, the store and load data.
REQ-011 SHALL have port trace_valid, output, 1, head entry available.
REQ-012 SHALL have port trace_ready, input, 1, consumer accepts the head entry.
REQ-013 SHALL have port trace_data, output, DATA_W+16, the head entry: [DATA_W+15:DATA_W+14] type, [DATA_W+13:DATA_W] tag, [DATA_W-1:0] data.
REQ-014 SHALL have port count, output, $clog2(DEPTH)+1, current occupancy.
REQ-015 SHALL have port drop_cnt, output, 16, the count of lost events.

Function
REQ-016 SHALL form a register event when reg_write_sig=1 and reg_num!=0: type 00, tag = reg_num zero-extended, data = reg_data.
REQ-017 SHALL ignore writebacks to reg_num=0 (no push, no drop).
REQ-018 SHALL push at most one entry per cycle, on the rising edge of the cycle in which the event is present.
REQ-019 SHALL, when more than one event occurs in the same cycle, push by priority register > store > load and increment drop_cnt once per event not pushed.
REQ-020 SHALL pop the head when trace_valid=1 and trace_ready=1 at a rising edge.
REQ-021 SHALL present the first-written entry first (FWFT): an entry pushed into an empty FIFO gives trace_valid=1 in the next cycle.
REQ-022 SHALL hold trace_data stable while trace_valid=1 and trace_ready=0.
REQ-023 SHALL drive trace_data to zero when trace_valid=0.
REQ-024 SHALL, when full and no pop occurs, discard the push and increment drop_cnt.
REQ-025 SHALL, when full with a simultaneous pop, accept the push; count stays at DEPTH.
REQ-026 SHALL, when empty with a simultaneous push and trace_ready=1, not pop; count becomes 1.
REQ-027 SHALL wrap read and write pointers modulo DEPTH.
REQ-028 SHALL saturate drop_cnt at 16'hFFFF.
REQ-029 SHALL keep trace_valid=1 exactly when count!=0.

Reset
REQ-030 SHALL, on reset=1 at a rising edge, set count=0, both pointers=0, drop_cnt=0, trace_valid=0 and trace_data=0.
REQ-031 SHALL, on reset asserted mid-operation, discard all stored entries and ignore events and pops in that cycle.
REQ-032 SHALL accept events from the first cycle after reset deasserts.

Configuration
REQ-033 SHALL, with TRACE_MEM_EN defined, form store events (wr=1: type 01, tag = addr, data = wr_data) and load events (rd=1: type 10, tag = addr, data = rd_data).
REQ-034 SHALL, without TRACE_MEM_EN, ignore wr, rd, addr, wr_data and rd_data; only register events exist and drop_cnt counts only full-FIFO drops.
REQ-035 SHALL never emit type 11.

Verification
REQ-036 Reset, then reg_write_sig=1, reg_num=5, reg_data=32'hDEADBEEF for 1 cycle with trace_ready=0 -> next cycle trace_valid=1, trace_data={2'b00,14'd5,32'hDEADBEEF}, count=1.
REQ-037 Writeback to reg_num=0 with reg_data=32'h1234 -> count stays 0, drop_cnt stays 0.
REQ-038 DEPTH=8: 10 register events with trace_ready=0 -> count=8, drop_cnt=2; then trace_ready=1 -> entries 1..8 drain in order.
REQ-039 FIFO full, with a push and a pop in the same cycle -> count stays 8, new entry at tail, drop_cnt unchanged.
REQ-040 TRACE_MEM_EN defined: reg write (reg_num=3) + wr=1, addr=9'h010 in the same cycle -> one type 00 entry, drop_cnt=1; store alone next cycle -> {2'b01,14'h010,wr_data}.
REQ-041 Reset asserted with count=5 -> next cycle count=0, trace_valid=0, drop_cnt=0.
